route_lpm_searcher: RTL and testbench
=====================================

Name: route_lpm_searcher

Overview:
- Routing-table store and lookup engine for the switch router.
- An initialisation port loads up to MAX_ENTRIES 256-bit route entries while init_mode=1.
- In run mode (init_mode=0), each lookup scans the table sequentially and returns the longest-prefix match for a destination IPv4 address, with next-hop and flag fields.
- Sits behind the table reader that streams entries from ROM.

Parameters:
- MAX_ENTRIES, 64: number of table entries; init_entry_addr width is clog2(MAX_ENTRIES).
- ENTRY_WIDTH, 256: entry width; fixed at 256, and the field map below assumes it.
- IP_WIDTH, 32: IP address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- init_mode  in  1  1 = table load mode; 0 = lookup mode.
- init_entry_data  in  256  entry to write.
- init_entry_addr  in  clog2(MAX_ENTRIES)  entry index.
- init_entry_wr  in  1  write strobe.
- lookup_valid  in  1  lookup request pulse.
- lookup_dst_ip  in  32  destination IP.
- resp_valid  out  1  one-cycle response pulse.
- resp_found  out  1  a matching entry existed.
- resp_out_port  out  16  egress port.
- resp_out_qp  out  16  egress QP.
- resp_next_hop_ip  out  32  next-hop IP.
- resp_next_hop_port  out  16  next-hop port.
- resp_next_hop_qp  out  16  next-hop QP.
- resp_next_hop_mac  out  48  next-hop MAC.
- resp_is_direct_host  out  1  flag from the winning entry.
- resp_is_broadcast  out  1  flag from the winning entry.
- resp_is_default_route  out  1  winner is a default route.

Interface rule: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Entry field map:
  - [31:0] dst_ip; [63:32] dst_mask
  - [79:64] out_port; [95:80] out_qp
  - [127:96] next_hop_ip; [143:128] next_hop_port; [159:144] next_hop_qp
  - [207:160] next_hop_mac
  - [208] is_direct_host; [209] is_broadcast; [210] is_default_route
  - [254:211] reserved, ignored
  - [255] valid
- Reset:
  - All entry valid bits cleared; FSM returns to IDLE.
  - resp_valid=0 and all resp_* outputs 0.
  - A scan in progress is aborted and produces no response.
- Table write: on a clk edge with init_mode=1 and init_entry_wr=1, entry[init_entry_addr] <= init_entry_data.
  - Writes while init_mode=0 are ignored.
  - Out-of-range addresses are ignored.
  - Rewriting an address overwrites it.
- Match rule: entry i matches when valid=1 and (lookup_dst_ip & dst_mask) == (dst_ip & dst_mask).
  - Masks are contiguous.
  - An entry is a default route when is_default_route=1 or dst_mask=0.
- Priority:
  - A non-default match beats a default match.
  - Among matches of the same class, the numerically larger dst_mask (longer prefix) wins.
  - On equal masks, the lowest index wins.
- FSM states:
  - IDLE: lookup_valid=1 with init_mode=0 latches lookup_dst_ip, clears the best-match registers, index=0, and moves to SCAN. lookup_valid is ignored when init_mode=1 or when the FSM is not in IDLE (no queueing).
  - SCAN: evaluates one entry per cycle and updates the best-match register per the priority rule. After index MAX_ENTRIES-1, moves to RESP.
  - RESP: registers the winner's fields onto the outputs and pulses resp_valid for exactly one cycle, then returns to IDLE.
- Latency: lookup_valid sampled at edge N produces resp_valid high after edge N+MAX_ENTRIES+1 (66 cycles for the default). Back-to-back lookups are accepted from the cycle after the resp_valid pulse.
- No match: resp_found=0 and all data and flag outputs 0, still with a resp_valid pulse.
- resp_* data outputs hold their value until the next response. resp_valid is 0 outside the pulse.
- resp_is_direct_host and resp_is_broadcast copy the winning entry's bits. resp_is_default_route=1 when the winner is a default route.
- A table write during SCAN (init_mode toggled to 1 mid-scan) is allowed. Entries at indices not yet scanned use the new contents; the scan always completes.
- An empty table (all invalid) returns resp_found=0.

Test Plan:
1. Reset, then lookup 10.0.0.5 with init_mode=0 -> one resp_valid pulse after 66 cycles, resp_found=0, all fields 0.
2. Load entry 0 (dst 10.0.0.0/255.255.255.0, out_port=2, out_qp=0x11, nh_ip=10.0.0.1, nh_mac=0x0A0B0C0D0E0F, valid), then lookup 10.0.0.5 -> found=1, out_port=2, out_qp=0x11, next_hop_mac=0x0A0B0C0D0E0F, default=0.
3. Add entry 1 (10.0.0.0/255.255.0.0, out_port=3) and entry 2 (mask 0, out_port=7). Lookup 10.0.0.5 -> out_port=2. Lookup 10.0.9.9 -> out_port=3. Lookup 192.168.1.1 -> out_port=7, is_default_route=1.
4. Entry 3 (10.0.0.5/255.255.255.255, bit208=1, bit209=0, valid) -> lookup 10.0.0.5 gives out_port of entry 3, is_direct_host=1, is_broadcast=0.
5. Write with init_mode=0 to a free index -> entry absent and the lookup is unaffected. lookup_valid pulsed during SCAN or with init_mode=1 -> ignored, exactly one response.
6. Assert rst_n low mid-scan -> no resp_valid, outputs 0, table empty (next lookup gives found=0).

Source files
------------

// File: rtl/route_lpm_searcher.sv
`default_nettype none
// =============================================================================
// Module  : route_lpm_searcher
// Purpose : Routing-table store with a one-entry-per-cycle longest-prefix scan.
// Revision: 1.0 - initial release
// =============================================================================
module route_lpm_searcher #(
    parameter int MAX_ENTRIES = 64,
    parameter int ENTRY_WIDTH = 256,
    parameter int IP_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init_mode,
    input  logic [ENTRY_WIDTH-1:0]         init_entry_data,
    input  logic [$clog2(MAX_ENTRIES)-1:0] init_entry_addr,
    input  logic                           init_entry_wr,
    input  logic                           lookup_valid,
    input  logic [IP_WIDTH-1:0]            lookup_dst_ip,
    output logic                           resp_valid,
    output logic                           resp_found,
    output logic [15:0]                    resp_out_port,
    output logic [15:0]                    resp_out_qp,
    output logic [31:0]                    resp_next_hop_ip,
    output logic [15:0]                    resp_next_hop_port,
    output logic [15:0]                    resp_next_hop_qp,
    output logic [47:0]                    resp_next_hop_mac,
    output logic                           resp_is_direct_host,
    output logic                           resp_is_broadcast,
    output logic                           resp_is_default_route
);
    localparam int            AW       = $clog2(MAX_ENTRIES);
    localparam logic [AW-1:0] LAST_IDX = AW'(MAX_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic [IP_WIDTH-1:0]      dst_q, dst_d;
    logic                     best_found_q, best_found_d;
    logic [210:32]            best_q, best_d;
    logic [MAX_ENTRIES-1:0]   valid_q, valid_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_found_q, resp_found_d;
    logic                     resp_default_q, resp_default_d;
    logic [209:64]            resp_fields_q, resp_fields_d;

    // Only bits [210:0] are stored; the valid bit lives in valid_q so it can be reset.
    logic [210:0]             table_q [MAX_ENTRIES];
    logic                     wr_en;
    logic [210:0]             cur_entry;
    logic                     cur_valid, cur_match, cur_default, best_default, cur_better;
    logic                     unused_reserved;

    assign unused_reserved = ^init_entry_data[254:211];

    assign wr_en = init_mode && init_entry_wr &&
                   ({1'b0, init_entry_addr} < (AW+1)'(MAX_ENTRIES));

    assign cur_entry    = table_q[idx_q];
    assign cur_valid    = valid_q[idx_q];
    assign cur_match    = cur_valid &&
                          ((dst_q & cur_entry[63:32]) == (cur_entry[31:0] & cur_entry[63:32]));
    assign cur_default  = cur_entry[210] || (cur_entry[63:32] == 32'd0);
    assign best_default = best_q[210] || (best_q[63:32] == 32'd0);
    // Non-default beats default; within a class the longer mask wins; ties keep the earlier index.
    assign cur_better   = cur_match &&
                          (!best_found_q ||
                           (!cur_default && best_default) ||
                           ((cur_default == best_default) && (cur_entry[63:32] > best_q[63:32])));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[init_entry_addr] <= init_entry_data[210:0];
        end
    end

    always_comb begin
        valid_d        = valid_q;
        state_d        = state_q;
        idx_d          = idx_q;
        dst_d          = dst_q;
        best_found_d   = best_found_q;
        best_d         = best_q;
        resp_valid_d   = 1'b0;
        resp_found_d   = resp_found_q;
        resp_default_d = resp_default_q;
        resp_fields_d  = resp_fields_q;

        if (wr_en) begin
            valid_d[init_entry_addr] = init_entry_data[ENTRY_WIDTH-1];
        end

        case (state_q)
            S_IDLE: begin
                // resp_valid_q gate keeps the pulse cycle itself from accepting a new lookup.
                if (lookup_valid && !init_mode && !resp_valid_q) begin
                    dst_d        = lookup_dst_ip;
                    best_found_d = 1'b0;
                    best_d       = '0;
                    idx_d        = '0;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cur_better) begin
                    best_found_d = 1'b1;
                    best_d       = cur_entry[210:32];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_RESP;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_RESP: begin
                resp_valid_d   = 1'b1;
                resp_found_d   = best_found_q;
                resp_fields_d  = best_q[209:64];
                resp_default_d = best_found_q && best_default;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            dst_q          <= '0;
            best_found_q   <= 1'b0;
            best_q         <= '0;
            valid_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_found_q   <= 1'b0;
            resp_default_q <= 1'b0;
            resp_fields_q  <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            dst_q          <= dst_d;
            best_found_q   <= best_found_d;
            best_q         <= best_d;
            valid_q        <= valid_d;
            resp_valid_q   <= resp_valid_d;
            resp_found_q   <= resp_found_d;
            resp_default_q <= resp_default_d;
            resp_fields_q  <= resp_fields_d;
        end
    end

    assign resp_valid            = resp_valid_q;
    assign resp_found            = resp_found_q;
    assign resp_out_port         = resp_fields_q[79:64];
    assign resp_out_qp           = resp_fields_q[95:80];
    assign resp_next_hop_ip      = resp_fields_q[127:96];
    assign resp_next_hop_port    = resp_fields_q[143:128];
    assign resp_next_hop_qp      = resp_fields_q[159:144];
    assign resp_next_hop_mac     = resp_fields_q[207:160];
    assign resp_is_direct_host   = resp_fields_q[208];
    assign resp_is_broadcast     = resp_fields_q[209];
    assign resp_is_default_route = resp_default_q;

endmodule
`default_nettype wire

// File: tb/tb_route_lpm_searcher.sv
`default_nettype none
// =============================================================================
// Module  : tb_route_lpm_searcher
// Purpose : Directed plus randomized bench with a table-level LPM reference model.
// Revision: 1.0 - initial release
// =============================================================================
module tb_route_lpm_searcher;
    localparam int MAX_ENTRIES = 64;
    localparam int AW          = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_mode = 1'b0;
    logic [255:0]  init_entry_data = '0;
    logic [AW-1:0] init_entry_addr = '0;
    logic          init_entry_wr = 1'b0;
    logic          lookup_valid = 1'b0;
    logic [31:0]   lookup_dst_ip = '0;
    logic          resp_valid, resp_found, resp_is_direct_host, resp_is_broadcast, resp_is_default_route;
    logic [15:0]   resp_out_port, resp_out_qp, resp_next_hop_port, resp_next_hop_qp;
    logic [31:0]   resp_next_hop_ip;
    logic [47:0]   resp_next_hop_mac;

    route_lpm_searcher #(.MAX_ENTRIES(MAX_ENTRIES), .ENTRY_WIDTH(256), .IP_WIDTH(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .init_mode             (init_mode),
        .init_entry_data       (init_entry_data),
        .init_entry_addr       (init_entry_addr),
        .init_entry_wr         (init_entry_wr),
        .lookup_valid          (lookup_valid),
        .lookup_dst_ip         (lookup_dst_ip),
        .resp_valid            (resp_valid),
        .resp_found            (resp_found),
        .resp_out_port         (resp_out_port),
        .resp_out_qp           (resp_out_qp),
        .resp_next_hop_ip      (resp_next_hop_ip),
        .resp_next_hop_port    (resp_next_hop_port),
        .resp_next_hop_qp      (resp_next_hop_qp),
        .resp_next_hop_mac     (resp_next_hop_mac),
        .resp_is_direct_host   (resp_is_direct_host),
        .resp_is_broadcast     (resp_is_broadcast),
        .resp_is_default_route (resp_is_default_route)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: table contents, per-lookup snapshot of what each entry held when visited.
    logic [255:0] m_tbl  [MAX_ENTRIES];
    logic         m_v    [MAX_ENTRIES];
    logic [255:0] snap   [MAX_ENTRIES];
    logic         snap_v [MAX_ENTRIES];
    bit           busy = 1'b0;
    int           age  = 0;
    logic [31:0]  m_ip = '0;
    logic [148:0] exp_bus = '0;
    logic [148:0] dut_bus;
    bit           cmp_en = 1'b0;

    assign dut_bus = {resp_valid, resp_found, resp_out_port, resp_out_qp, resp_next_hop_ip,
                      resp_next_hop_port, resp_next_hop_qp, resp_next_hop_mac,
                      resp_is_direct_host, resp_is_broadcast, resp_is_default_route};

    function automatic logic [147:0] lpm_result(input logic [31:0] ip);
        int           best     = -1;
        logic [32:0]  best_key = '0;
        logic [32:0]  key;
        logic [255:0] e;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            e = snap[i];
            if (snap_v[i] && ((ip & e[63:32]) == (e[31:0] & e[63:32]))) begin
                key = {!(e[210] || (e[63:32] == 32'd0)), e[63:32]};
                if (best < 0 || key > best_key) begin
                    best     = i;
                    best_key = key;
                end
            end
        end
        if (best < 0) return '0;
        e = snap[best];
        return {1'b1, e[79:64], e[95:80], e[127:96], e[143:128], e[159:144], e[207:160],
                e[208], e[209], ~best_key[32]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_ENTRIES; i++) m_v[i] = 1'b0;
            busy    = 1'b0;
            age     = 0;
            exp_bus = '0;
        end else begin
            exp_bus[148] = 1'b0;
            if (busy) begin
                age++;
                if (age <= MAX_ENTRIES) begin
                    snap[age-1]   = m_tbl[age-1];
                    snap_v[age-1] = m_v[age-1];
                end else if (age == MAX_ENTRIES + 1) begin
                    exp_bus = {1'b1, lpm_result(m_ip)};
                end else begin
                    busy = 1'b0;
                end
            end else if (lookup_valid && !init_mode) begin
                busy = 1'b1;
                age  = 0;
                m_ip = lookup_dst_ip;
            end
            if (init_mode && init_entry_wr) begin
                m_tbl[init_entry_addr] = init_entry_data;
                m_v[init_entry_addr]   = init_entry_data[255];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (dut_bus !== exp_bus) begin
                failures++;
                $display("FAIL model_compare t=%0t dut=%h model=%h", $time, dut_bus, exp_bus);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] dst, input logic [31:0] mask,
                                        input logic [15:0] op, input logic [15:0] qp,
                                        input logic [31:0] nhip, input logic [15:0] nhport,
                                        input logic [15:0] nhqp, input logic [47:0] mac,
                                        input logic dh, input logic bc, input logic dr,
                                        input logic v);
        logic [255:0] e = '0;
        e[31:0]    = dst;
        e[63:32]   = mask;
        e[79:64]   = op;
        e[95:80]   = qp;
        e[127:96]  = nhip;
        e[143:128] = nhport;
        e[159:144] = nhqp;
        e[207:160] = mac;
        e[208]     = dh;
        e[209]     = bc;
        e[210]     = dr;
        e[255]     = v;
        return e;
    endfunction

    task automatic write_entry(input int addr, input logic [255:0] d, input logic mode);
        @(negedge clk);
        init_mode       = mode;
        init_entry_wr   = 1'b1;
        init_entry_addr = AW'(addr);
        init_entry_data = d;
        @(negedge clk);
        init_mode     = 1'b0;
        init_entry_wr = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] ip, output int lat);
        @(negedge clk);
        lookup_valid  = 1'b1;
        lookup_dst_ip = ip;
        @(negedge clk);
        lookup_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (resp_valid !== 1'b1) chk("resp_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic count_pulses(input int ncyc, output int n, output logic [15:0] port);
        n    = 0;
        port = '0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                n++;
                port = resp_out_port;
            end
        end
    endtask

    localparam logic [31:0] IP_A = 32'h0A00_0005;  // 10.0.0.5
    localparam logic [31:0] IP_B = 32'h0A00_0909;  // 10.0.9.9
    localparam logic [31:0] IP_C = 32'hC0A8_0101;  // 192.168.1.1

    initial begin
        int            lat;
        int            n;
        logic [15:0]   port;
        logic [31:0]   bases [4];
        logic [31:0]   base, mask, ip;
        logic [255:0]  e;
        int            len;

        bases[0] = 32'h0A00_0000;
        bases[1] = 32'hC0A8_0000;
        bases[2] = 32'hAC10_0000;
        bases[3] = 32'h0A01_0000;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_outputs", 64'(dut_bus == '0), 64'd1);

        // Empty table
        do_lookup(IP_A, lat);
        chk("empty_latency", 64'(lat), 64'd66);
        chk("empty_found", 64'(resp_found), 64'd0);
        chk("empty_port", 64'(resp_out_port), 64'd0);
        chk("empty_mac", 64'(resp_next_hop_mac), 64'd0);

        write_entry(0, mk(32'h0A00_0000, 32'hFFFF_FF00, 16'd2, 16'h11, 32'h0A00_0001, 16'd0, 16'd0,
                          48'h0A0B_0C0D_0E0F, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        do_lookup(IP_A, lat);
        chk("e0_found", 64'(resp_found), 64'd1);
        chk("e0_port", 64'(resp_out_port), 64'd2);
        chk("e0_qp", 64'(resp_out_qp), 64'h11);
        chk("e0_mac", 64'(resp_next_hop_mac), 64'h0A0B_0C0D_0E0F);
        chk("e0_default", 64'(resp_is_default_route), 64'd0);

        write_entry(1, mk(32'h0A00_0000, 32'hFFFF_0000, 16'd3, 16'h22, 32'h0A00_0002, 16'd5, 16'd6,
                          48'h1111_2222_3333, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        write_entry(2, mk(32'h0000_0000, 32'h0000_0000, 16'd7, 16'h33, 32'h0A00_00FE, 16'd8, 16'd9,
                          48'h4444_5555_6666, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
        do_lookup(IP_A, lat);
        chk("lpm24_port", 64'(resp_out_port), 64'd2);
        do_lookup(IP_B, lat);
        chk("lpm16_port", 64'(resp_out_port), 64'd3);
        do_lookup(IP_C, lat);
        chk("dflt_port", 64'(resp_out_port), 64'd7);
        chk("dflt_flag", 64'(resp_is_default_route), 64'd1);

        write_entry(3, mk(32'h0A00_0005, 32'hFFFF_FFFF, 16'd4, 16'h44, 32'h0A00_0005, 16'd1, 16'd2,
                          48'h7777_8888_9999, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1);
        do_lookup(IP_A, lat);
        chk("host_port", 64'(resp_out_port), 64'd4);
        chk("host_dh", 64'(resp_is_direct_host), 64'd1);
        chk("host_bc", 64'(resp_is_broadcast), 64'd0);

        // Write outside init mode is dropped
        write_entry(10, mk(32'hC0A8_0000, 32'hFFFF_0000, 16'd9, 16'd0, 32'd0, 16'd0, 16'd0, 48'd0,
                           1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
        do_lookup(IP_C, lat);
        chk("runmode_wr_port", 64'(resp_out_port), 64'd7);

        // Lookup while in init mode is ignored
        @(negedge clk);
        init_mode    = 1'b1;
        lookup_valid = 1'b1;
        lookup_dst_ip = IP_A;
        @(negedge clk);
        init_mode    = 1'b0;
        lookup_valid = 1'b0;
        count_pulses(100, n, port);
        chk("initmode_lookup_pulses", 64'(n), 64'd0);

        // Mid-scan write ahead of the scan pointer, plus stray lookups during the scan
        @(negedge clk);
        lookup_valid  = 1'b1;
        lookup_dst_ip = IP_B;
        @(negedge clk);
        lookup_valid = 1'b0;
        repeat (8) @(negedge clk);
        init_mode       = 1'b1;
        init_entry_wr   = 1'b1;
        init_entry_addr = AW'(50);
        init_entry_data = mk(32'h0A00_0900, 32'hFFFF_FF00, 16'd12, 16'h55, 32'h0A00_0901, 16'd3, 16'd4,
                             48'hABCD_EF01_2345, 1'b0, 1'b1, 1'b0, 1'b1);
        lookup_valid    = 1'b1;
        lookup_dst_ip   = IP_C;
        @(negedge clk);
        init_mode     = 1'b0;
        init_entry_wr = 1'b0;
        lookup_valid  = 1'b1;
        @(negedge clk);
        lookup_valid = 1'b0;
        count_pulses(150, n, port);
        chk("midscan_pulses", 64'(n), 64'd1);
        chk("midscan_port", 64'(port), 64'd12);

        // Reset in the middle of a scan
        @(negedge clk);
        lookup_valid  = 1'b1;
        lookup_dst_ip = IP_A;
        @(negedge clk);
        lookup_valid = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_pulses(100, n, port);
        chk("rst_midscan_pulses", 64'(n), 64'd0);
        chk("rst_port", 64'(resp_out_port), 64'd0);
        chk("rst_found", 64'(resp_found), 64'd0);
        do_lookup(IP_A, lat);
        chk("rst_table_empty", 64'(resp_found), 64'd0);

        // Randomized table and lookups; correctness carried by the model compare
        for (int k = 0; k < 40; k++) begin
            base = bases[$urandom_range(0, 3)];
            len  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(8, 32);
            mask = (len == 0) ? 32'd0 : (32'hFFFF_FFFF << (32 - len));
            e = mk((base | ($urandom & 32'h0000_FFFF)) & mask, mask, 16'($urandom), 16'($urandom),
                   $urandom, 16'($urandom), 16'($urandom), {16'($urandom), 32'($urandom)},
                   1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) != 0));
            e[254:211] = {12'($urandom), 32'($urandom)};
            write_entry($urandom_range(0, MAX_ENTRIES - 1), e, 1'b1);
        end
        for (int k = 0; k < 14; k++) begin
            ip = (k % 5 == 4) ? $urandom : (bases[$urandom_range(0, 3)] | ($urandom & 32'h0000_FFFF));
            if (k % 3 == 1) begin
                @(negedge clk);
                lookup_valid  = 1'b1;
                lookup_dst_ip = ip;
                @(negedge clk);
                lookup_valid = 1'b0;
                repeat ($urandom_range(1, 55)) @(negedge clk);
                base = bases[$urandom_range(0, 3)];
                e = mk(base, 32'hFFFF_0000, 16'($urandom), 16'($urandom), $urandom, 16'($urandom),
                       16'($urandom), 48'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                write_entry($urandom_range(0, MAX_ENTRIES - 1), e, 1'b1);
                count_pulses(80, n, port);
                chk("rand_midscan_pulses", 64'(n), 64'd1);
            end else begin
                do_lookup(ip, lat);
                chk("rand_latency", 64'(lat), 64'd66);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
